chan_scan_sequencer: RTL and testbench

//  Parametrised filter-bank channel sequencer for the spectrogram extractor.
//  An ovf trigger starts one frame. Each channel enabled in a run-time mask is

---
 rtl/chan_scan_sequencer_pkg.sv | 14 +
 rtl/chan_scan_sequencer_if.sv | 36 +++
 rtl/chan_scan_sequencer_next_find.sv | 26 ++
 rtl/chan_scan_sequencer.sv | 130 +++++++++++++
 tb/tb_chan_scan_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/chan_scan_sequencer_pkg.sv
// Shared state encodings and default geometry for the spectrogram
// channel sequencer, mux and accumulator.
package chan_scan_sequencer_pkg;

   localparam int DEF_NUM_CH = 16;
   localparam int DEF_DWELL  = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

endpackage

// File: rtl/chan_scan_sequencer_if.sv
// Control and status bundle between the ovf/timer source and the
// channel scan sequencer.
interface chan_scan_sequencer_if
   import chan_scan_sequencer_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DWELL  = DEF_DWELL
);

   localparam int SEL_W = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(DWELL);

   logic              ovf;
   logic              en;
   logic              continuous;
   logic [NUM_CH-1:0] ch_mask;
   logic              clr_overrun;
   logic [SEL_W-1:0]  selection;
   logic [CNT_W-1:0]  counter;
   logic              sl;
   logic              rst;
   logic              busy;
   logic              frame_done;
   logic              overrun;

   modport master (
      output ovf, en, continuous, ch_mask, clr_overrun,
      input  selection, counter, sl, rst, busy, frame_done, overrun
   );

   modport slave (
      input  ovf, en, continuous, ch_mask, clr_overrun,
      output selection, counter, sl, rst, busy, frame_done, overrun
   );

endinterface

// File: rtl/chan_scan_sequencer_next_find.sv
// Finds the lowest set mask bit above cur_i, or the lowest set bit
// overall when first_i is high.
module chan_next_find #(
   parameter int NUM_CH = 16,
   parameter int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [SEL_W-1:0]  cur_i,
   input  logic              first_i,
   output logic [SEL_W-1:0]  nxt_o,
   output logic              none_o
);

   // Scan downward so the last hit written is the lowest qualifying bit.
   always_comb begin
      nxt_o  = '0;
      none_o = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i] && (first_i || (SEL_W'(i) > cur_i))) begin
            nxt_o  = SEL_W'(i);
            none_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/chan_scan_sequencer.sv
// Filter-bank channel sequencer: dwells on each masked channel, then
// pulses an accumulator clear; supports continuous mode and abort.
module chan_scan_sequencer
   import chan_scan_sequencer_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DWELL  = DEF_DWELL
) (
   input logic                  clk,
   input logic                  reset,
   chan_scan_sequencer_if.slave bus
);

   localparam int SEL_W = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(DWELL);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SEL_W-1:0]  ch_q, ch_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic              ovr_q, ovr_d;

   logic [SEL_W-1:0]  first_ch;
   logic [SEL_W-1:0]  next_ch;
   logic              first_none;
   logic              next_none;
   logic              start_ok;
   logic              busy;
   logic              clr_st;

   chan_next_find #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_first (
      .mask_i  (bus.ch_mask),
      .cur_i   ('0),
      .first_i (1'b1),
      .nxt_o   (first_ch),
      .none_o  (first_none)
   );

   chan_next_find #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_next (
      .mask_i  (mask_q),
      .cur_i   (ch_q),
      .first_i (1'b0),
      .nxt_o   (next_ch),
      .none_o  (next_none)
   );

   // An empty live mask never starts a frame.
   assign start_ok = bus.en && !first_none;
   assign busy     = (state_q != ST_IDLE);
   assign clr_st   = (state_q == ST_CLEAR);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ch_q    <= '0;
         mask_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         mask_q  <= mask_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ch_d    = ch_q;
      mask_d  = mask_q;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            ch_d  = '0;
            if (bus.ovf && start_ok) begin
               state_d = ST_SCAN;
               mask_d  = bus.ch_mask;
               ch_d    = first_ch;
            end
         end
         ST_SCAN: begin
            if (!bus.en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               ch_d    = '0;
            end else if (cnt_q == LAST) begin
               cnt_d = '0;
               if (next_none) begin
                  state_d = ST_CLEAR;
                  ch_d    = '0;
               end else begin
                  ch_d = next_ch;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_CLEAR: begin
            cnt_d   = '0;
            ch_d    = '0;
            state_d = ST_IDLE;
            if (bus.continuous && start_ok) begin
               state_d = ST_SCAN;
               mask_d  = bus.ch_mask;
               ch_d    = first_ch;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ch_d    = '0;
         end
      endcase
   end

   // A new trigger while busy beats a same-cycle clear request.
   assign ovr_d = (bus.ovf && busy) || (ovr_q && !bus.clr_overrun);

   assign bus.selection  = ch_q;
   assign bus.counter    = cnt_q;
   assign bus.sl         = (state_q == ST_SCAN) && (cnt_q == '0);
   assign bus.rst        = clr_st;
   assign bus.frame_done = clr_st;
   assign bus.busy       = busy;
   assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_chan_scan_sequencer.sv
// Bench for chan_scan_sequencer: two geometries (16x12 and 8x4) checked
// every cycle against a frame-schedule model.
module tb_chan_scan_sequencer;

   typedef struct packed {
      logic [1:0] kind;
      logic [3:0] sel;
      logic [3:0] cnt;
   } ent_t;

   typedef struct {
      logic [15:0] mask;
      bit          cont;
      int          n;
      int          a_sl, a_scan, a_rst;
      int          b_sl, b_scan, b_rst;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ovf, en, cont, clr;
   logic [15:0] mask;

   chan_scan_sequencer_if #(.NUM_CH(16), .DWELL(12)) ifa ();
   chan_scan_sequencer_if #(.NUM_CH(8),  .DWELL(4))  ifb ();

   assign ifa.ovf         = ovf;
   assign ifa.en          = en;
   assign ifa.continuous  = cont;
   assign ifa.ch_mask     = mask;
   assign ifa.clr_overrun = clr;
   assign ifb.ovf         = ovf;
   assign ifb.en          = en;
   assign ifb.continuous  = cont;
   assign ifb.ch_mask     = mask[7:0];
   assign ifb.clr_overrun = clr;

   chan_scan_sequencer #(.NUM_CH(16), .DWELL(12)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   chan_scan_sequencer #(.NUM_CH(8), .DWELL(4)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   always #5 clk = ~clk;

   int   checks   = 0;
   int   failures = 0;
   int   nch[2]   = '{16, 8};
   int   dw[2]    = '{12, 4};
   ent_t sch[2][0:199];
   int   len[2];
   int   pos[2];
   ent_t cur[2];
   bit   ovr[2];

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int obs(int k);
      if (k == 0)
         return int'({ifa.selection, ifa.counter, ifa.sl, ifa.rst,
                      ifa.busy, ifa.frame_done, ifa.overrun});
      return int'({1'b0, ifb.selection, 2'b00, ifb.counter, ifb.sl,
                   ifb.rst, ifb.busy, ifb.frame_done, ifb.overrun});
   endfunction

   function automatic int expv(int k);
      return int'({cur[k].sel, cur[k].cnt,
                   cur[k].kind == 2'd1 && cur[k].cnt == 4'd0,
                   cur[k].kind == 2'd2, cur[k].kind != 2'd0,
                   cur[k].kind == 2'd2, ovr[k]});
   endfunction

   // Whole frame laid out up front: every (channel, dwell) slot then CLEAR.
   task automatic build(int k, logic [15:0] m);
      len[k] = 0;
      for (int i = 0; i < nch[k]; i++)
         if (m[i])
            for (int c = 0; c < dw[k]; c++) begin
               sch[k][len[k]] = '{kind: 2'd1, sel: 4'(i), cnt: 4'(c)};
               len[k]++;
            end
      sch[k][len[k]] = '{kind: 2'd2, sel: 4'd0, cnt: 4'd0};
      len[k]++;
      pos[k] = 0;
   endtask

   task automatic pop(int k);
      cur[k] = sch[k][pos[k]];
      pos[k]++;
   endtask

   task automatic mstep(int k);
      logic [15:0] mk;
      bit          was_busy;
      mk       = (k == 0) ? mask : {8'h00, mask[7:0]};
      was_busy = (cur[k].kind != 2'd0);
      if (reset) begin
         cur[k] = '0;
         ovr[k] = 1'b0;
      end else begin
         ovr[k] = (ovf && was_busy) ? 1'b1 : (clr ? 1'b0 : ovr[k]);
         case (cur[k].kind)
            2'd0: if (ovf && en && mk != 0) begin
               build(k, mk);
               pop(k);
            end
            2'd1: if (!en) cur[k] = '0;
                  else pop(k);
            default: if (cont && en && mk != 0) begin
               build(k, mk);
               pop(k);
            end else cur[k] = '0;
         endcase
      end
   endtask

   task automatic step();
      mstep(0);
      mstep(1);
      @(posedge clk);
      #1;
      chk("cycle_a", obs(0), expv(0));
      chk("cycle_b", obs(1), expv(1));
   endtask

   task automatic drain();
      for (int i = 0; i < 600 && (cur[0].kind != 0 || cur[1].kind != 0); i++)
         step();
      chk("drain_idle", int'(ifa.busy | ifb.busy), 0);
   endtask

   vec_t tv[3];
   int   asl, ascan, arst, bsl, bscan, brst;
   bit   found;

   initial begin
      tv[0] = '{16'hFFFF, 1'b0, 220, 16, 192, 1, 8, 32, 1};
      tv[1] = '{16'h8005, 1'b0, 60, 3, 36, 1, 2, 8, 1};
      tv[2] = '{16'h0003, 1'b1, 100, 8, 96, 4, 23, 89, 11};

      cur[0] = '0; cur[1] = '0;
      ovr[0] = 1'b0; ovr[1] = 1'b0;
      reset = 1'b1; ovf = 1'b0; en = 1'b1; cont = 1'b0; clr = 1'b0;
      mask = 16'h0;
      step();
      step();
      chk("rst_sel", int'(ifa.selection), 0);
      chk("rst_cnt", int'(ifa.counter), 0);
      chk("rst_sl", int'(ifa.sl), 0);
      chk("rst_rst", int'(ifa.rst), 0);
      chk("rst_busy", int'(ifa.busy), 0);
      chk("rst_fd", int'(ifa.frame_done), 0);
      chk("rst_ovr", int'(ifa.overrun), 0);
      reset = 1'b0;
      step();

      for (int r = 0; r < 3; r++) begin
         asl = 0; ascan = 0; arst = 0; bsl = 0; bscan = 0; brst = 0;
         mask = tv[r].mask;
         cont = tv[r].cont;
         ovf  = 1'b1;
         for (int c = 0; c < tv[r].n; c++) begin
            step();
            ovf = 1'b0;
            asl   += int'(ifa.sl);
            ascan += int'(ifa.busy && !ifa.rst);
            arst  += int'(ifa.rst);
            bsl   += int'(ifb.sl);
            bscan += int'(ifb.busy && !ifb.rst);
            brst  += int'(ifb.rst);
         end
         cont = 1'b0;
         drain();
         chk("vec_a_sl", asl, tv[r].a_sl);
         chk("vec_a_scan", ascan, tv[r].a_scan);
         chk("vec_a_rst", arst, tv[r].a_rst);
         chk("vec_b_sl", bsl, tv[r].b_sl);
         chk("vec_b_scan", bscan, tv[r].b_scan);
         chk("vec_b_rst", brst, tv[r].b_rst);
      end

      // Overrun at SCAN cycle 50, then clear-vs-set priority.
      mask = 16'hFFFF;
      ovf  = 1'b1;
      step();
      ovf = 1'b0;
      for (int i = 0; i < 49; i++) step();
      ovf = 1'b1;
      step();
      ovf = 1'b0;
      chk("ovr_set", int'(ifa.overrun), 1);
      chk("ovr_still_busy", int'(ifa.busy), 1);
      clr = 1'b1; ovf = 1'b1;
      step();
      clr = 1'b0; ovf = 1'b0;
      chk("ovr_set_wins", int'(ifa.overrun), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("ovr_clr", int'(ifa.overrun), 0);
      drain();

      // Abort at selection 4, counter 7, then a fresh frame.
      ovf = 1'b1;
      step();
      ovf   = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (ifa.selection == 4'd4 && ifa.counter == 4'd7) found = 1'b1;
         else step();
      end
      chk("abort_reach", int'(found), 1);
      en = 1'b0;
      step();
      chk("abort_sel", int'(ifa.selection), 0);
      chk("abort_cnt", int'(ifa.counter), 0);
      chk("abort_rst", int'(ifa.rst), 0);
      chk("abort_fd", int'(ifa.frame_done), 0);
      chk("abort_busy", int'(ifa.busy), 0);
      en  = 1'b1;
      ovf = 1'b1;
      step();
      ovf = 1'b0;
      chk("restart_sel", int'(ifa.selection), 0);
      chk("restart_sl", int'(ifa.sl), 1);
      for (int i = 0; i < 20; i++) step();

      // Reset mid-frame, then an empty-mask trigger.
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mreset_outs", obs(0), 0);
      chk("mreset_rst", int'(ifa.rst), 0);
      mask = 16'h0;
      ovf  = 1'b1;
      step();
      ovf = 1'b0;
      chk("empty_busy", int'(ifa.busy), 0);
      chk("empty_ovr", int'(ifa.overrun), 0);
      step();

      for (int i = 0; i < 3000; i++) begin
         ovf = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 99) == 0) cont = ~cont;
         clr   = ($urandom_range(0, 29) == 0);
         reset = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       mask = 16'h0;
               1:       mask = 16'($urandom()) & 16'hFF00;
               default: mask = 16'($urandom());
            endcase
         end
         step();
      end
      reset = 1'b0; en = 1'b1; cont = 1'b0; ovf = 1'b0; clr = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
